mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Parametrised multicycle control unit for the MIPS-subset datapath.
- Drives every datapath mux select and write enable from the IR opcode/funct fields.
- Adds what the fixed control path lacks: a variable-latency memory handshake (req/ready), a wait-state timeout with a sticky fault, and a direct-register PC source for JR.

Parameters:
- OPW, 6, opcode field width
- FUNCTW, 6, funct field width
- ALUOPW, 6, ALU op code width
- ALU_ADD, 6'd0, ALU op code for add
- ALU_SUB, 6'd1, ALU op code for subtract
- ALU_XOR, 6'd2, ALU op code for xor
- ALU_SLT, 6'd3, ALU op code for set-less-than
- WAIT_MAX, 15, maximum cycles mem_req may stay unanswered
- CNTW, 32, performance counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- opcode  in  OPW  IR opcode
- funct  in  FUNCTW  IR funct
- zero  in  1  ALU zero flag, valid in the same cycle
- mem_ready  in  1  memory access completes this cycle
- mem_req  out  1  memory access request
- pc_we  out  1  PC write enable
- mem_in  out  1  memory address select: 0=ALU result reg, 1=PC
- mem_we  out  1  memory write enable
- ir_we  out  1  IR write enable
- alu_srca  out  1  ALU A select: 0=A, 1=PC
- alu_srcb  out  2  ALU B select: 0=const 1, 1=B, 2=sign-extended imm, 3=sign-extended imm<<2
- alu_op  out  ALUOPW  ALU op code
- pc_src  out  2  PC select: 0=jump concat, 1=ALU out, 2=ALU result reg, 3=A reg
- dst  out  2  register destination: 0=Rt, 1=Rd, 2=r31
- reg_in  out  1  register write data: 0=ALU result reg, 1=MDR
- reg_we  out  1  register file write enable
- fault  out  1  sticky fault indicator

Behaviour:
- Outputs are decoded combinationally from state, mem_ready and zero. Outside the states listed below, every enable and select is 0 and alu_op=ALU_ADD.
- Reset (asynchronous): state=FETCH, wait counter=0, fault=0. Reset mid-access drops mem_req immediately. No write enable asserts while reset is high.
- FETCH:
  - mem_req=1, mem_in=1.
  - On mem_ready: ir_we=1, pc_we=1, alu_srca=1, alu_srcb=0, ADD, pc_src=1 (PC+1); next state DECODE.
  - Otherwise hold in FETCH.
- DECODE: alu_srca=1, alu_srcb=3, ADD (branch target latched into ALU result reg). Dispatch:
  - op 0x00 with funct 0x20/0x22/0x2A -> EXEC_R; funct 0x08 -> JR
  - 0x23 or 0x2B -> MEM_ADDR
  - 0x08 or 0x0E -> EXEC_I
  - 0x05 -> BNE
  - 0x02 -> J
  - 0x03 -> JAL
  - anything else -> FAULT
- EXEC_R: srcb=1; alu_op = ADD/SUB/SLT per funct -> WB_R.
- WB_R: dst=1, reg_in=0, reg_we=1 -> FETCH.
- EXEC_I: srcb=2; ADD for 0x08, XOR for 0x0E -> WB_I.
- WB_I: dst=0, reg_in=0, reg_we=1 -> FETCH.
- MEM_ADDR: srcb=2, ADD -> MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: mem_req=1, mem_in=0; hold until mem_ready -> MEM_WB.
- MEM_WB: dst=0, reg_in=1, reg_we=1 -> FETCH.
- MEM_WR: mem_req=1, mem_in=0, mem_we=mem_ready; on mem_ready -> FETCH.
- BNE: srcb=1, SUB; if zero=0 then pc_src=2, pc_we=1. -> FETCH.
- J: pc_src=0, pc_we=1 -> FETCH.
- JAL:
  - pc_src=0, pc_we=1, dst=2, reg_we=1.
  - Write data is PC via alu_srca=1, alu_srcb=0, SUB-free path: the ALU result reg already holds PC+SE<<2, so JAL instead uses a JAL_LINK state first.
  - JAL_LINK: alu_srca=1, alu_srcb=0, ADD, latched. Then JAL: reg_in=0, dst=2, reg_we=1, pc_src=0, pc_we=1.
  - Link value = PC+2 (word addressing; documented).
- JR: pc_src=3, pc_we=1 -> FETCH.
- Wait counter:
  - Increments each cycle that mem_req=1 and mem_ready=0; clears on mem_ready or on leaving a memory state.
  - Reaching WAIT_MAX -> FAULT.
- FAULT: terminal; fault=1, all enables 0. Exit only by reset.
- mem_ready high outside a memory state is ignored.
- Latency: R/I types 4 cycles, LW 5, SW 4, BNE/J/JR 3, JAL 4 (zero wait states).

Optional Feature:
- Macro MC_CTRL_PERF_CNT_EN.
- Defined: adds outputs cycle_cnt[CNTW] and retire_cnt[CNTW], both reset to 0.
  - cycle_cnt increments every cycle unless in FAULT.
  - retire_cnt increments on every transition into FETCH from a non-FETCH state.
  - Both wrap modulo 2^CNTW.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- ADD (op 0, funct 0x20), mem_ready tied 1 -> states FETCH, DECODE, EXEC_R, WB_R, FETCH; reg_we=1, dst=1 only in cycle 4; alu_op=ALU_ADD in EXEC_R.
- LW (0x23) with mem_ready delayed 3 cycles during MEM_RD -> mem_req high 4 cycles; then MEM_WB with reg_in=1, dst=0, reg_we=1; 8 cycles total.
- BNE (0x05): zero=1 -> pc_we=0 in BNE. zero=0 -> pc_we=1, pc_src=2.
- FETCH with mem_ready held 0, WAIT_MAX=15 -> fault=1 after 15 cycles, mem_req=0 thereafter. Reset pulse -> fault=0, state FETCH.
- Undefined opcode 0x3F -> FAULT immediately after DECODE. Reset asserted mid-MEM_WR -> mem_we and mem_req drop asynchronously.
- With MC_CTRL_PERF_CNT_EN defined: 3 ADDs at zero wait -> retire_cnt=3, cycle_cnt=12.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm -- multicycle control unit for the MIPS-subset datapath.
//
// Decodes the IR opcode/funct fields into every datapath mux select and write
// enable. Memory accesses use a req/ready handshake with a wait-state timeout
// that parks the FSM in a terminal FAULT state (left only through reset).
//
// Ports:
//   clk, reset          clock (rising edge) and asynchronous active-high reset
//   opcode, funct       IR fields
//   zero                ALU zero flag (same-cycle)
//   mem_ready           memory access completes this cycle
//   mem_req, mem_in, mem_we        memory request / address select / write
//   pc_we, pc_src       PC write enable and source select
//   ir_we               IR write enable
//   alu_srca, alu_srcb, alu_op     ALU operand selects and op code
//   dst, reg_in, reg_we register-file destination, data select, write enable
//   fault               sticky fault indicator
//   cycle_cnt, retire_cnt          performance counters (optional)
//
// Optional feature: define MC_CTRL_PERF_CNT_EN to add the cycle_cnt and
// retire_cnt performance counter outputs.
//
// Outputs are a combinational decode of the registered state, mem_ready and
// zero, so mem_we and the BNE PC write follow those inputs in the same cycle.
// All write enables and mem_req are gated by reset so they drop the moment
// reset rises, even between clock edges.
// -----------------------------------------------------------------------------
module mc_ctrl_fsm #(
    parameter int                OPW      = 6,
    parameter int                FUNCTW   = 6,
    parameter int                ALUOPW   = 6,
    parameter logic [ALUOPW-1:0] ALU_ADD  = 6'd0,
    parameter logic [ALUOPW-1:0] ALU_SUB  = 6'd1,
    parameter logic [ALUOPW-1:0] ALU_XOR  = 6'd2,
    parameter logic [ALUOPW-1:0] ALU_SLT  = 6'd3,
    parameter int                WAIT_MAX = 15,
    parameter int                CNTW     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OPW-1:0]    opcode,
    input  logic [FUNCTW-1:0] funct,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              pc_we,
    output logic              mem_in,
    output logic              mem_we,
    output logic              ir_we,
    output logic              alu_srca,
    output logic [1:0]        alu_srcb,
    output logic [ALUOPW-1:0] alu_op,
    output logic [1:0]        pc_src,
    output logic [1:0]        dst,
    output logic              reg_in,
    output logic              reg_we,
    output logic              fault
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    output logic [CNTW-1:0]   cycle_cnt,
    output logic [CNTW-1:0]   retire_cnt
`endif
);

    localparam int WCW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    localparam logic [OPW-1:0]    OP_RTYPE = OPW'(6'h00);
    localparam logic [OPW-1:0]    OP_J     = OPW'(6'h02);
    localparam logic [OPW-1:0]    OP_JAL   = OPW'(6'h03);
    localparam logic [OPW-1:0]    OP_BNE   = OPW'(6'h05);
    localparam logic [OPW-1:0]    OP_ADDI  = OPW'(6'h08);
    localparam logic [OPW-1:0]    OP_XORI  = OPW'(6'h0E);
    localparam logic [OPW-1:0]    OP_LW    = OPW'(6'h23);
    localparam logic [OPW-1:0]    OP_SW    = OPW'(6'h2B);
    localparam logic [FUNCTW-1:0] F_JR     = FUNCTW'(6'h08);
    localparam logic [FUNCTW-1:0] F_ADD    = FUNCTW'(6'h20);
    localparam logic [FUNCTW-1:0] F_SUB    = FUNCTW'(6'h22);
    localparam logic [FUNCTW-1:0] F_SLT    = FUNCTW'(6'h2A);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
        S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BNE, S_J,
        S_JAL_LINK, S_JAL, S_JR, S_FAULT
    } state_t;

    state_t         state_r;
    logic [WCW-1:0] wait_cnt_r;
    logic           req_s, pc_we_s, mem_we_s, ir_we_s, reg_we_s;
    logic           timeout_s;

    // Enables are forced low while reset is high, independent of the clock.
    assign mem_req = req_s    & ~reset;
    assign pc_we   = pc_we_s  & ~reset;
    assign mem_we  = mem_we_s & ~reset;
    assign ir_we   = ir_we_s  & ~reset;
    assign reg_we  = reg_we_s & ~reset;
    assign fault   = (state_r == S_FAULT);

    // The cycle that would make the unanswered-request count reach WAIT_MAX.
    assign timeout_s = req_s & ~mem_ready & (wait_cnt_r == WCW'(WAIT_MAX - 1));

    // Output decode from state, mem_ready and zero.
    always_comb begin
        req_s    = 1'b0;
        pc_we_s  = 1'b0;
        mem_we_s = 1'b0;
        ir_we_s  = 1'b0;
        reg_we_s = 1'b0;
        mem_in   = 1'b0;
        alu_srca = 1'b0;
        alu_srcb = 2'd0;
        alu_op   = ALU_ADD;
        pc_src   = 2'd0;
        dst      = 2'd0;
        reg_in   = 1'b0;
        case (state_r)
            S_FETCH: begin
                req_s  = 1'b1;
                mem_in = 1'b1;
                if (mem_ready) begin
                    ir_we_s  = 1'b1;
                    pc_we_s  = 1'b1;
                    alu_srca = 1'b1;
                    pc_src   = 2'd1;
                end else begin
                    ir_we_s  = 1'b0;
                end
            end
            S_DECODE: begin
                alu_srca = 1'b1;
                alu_srcb = 2'd3;
            end
            S_EXEC_R: begin
                alu_srcb = 2'd1;
                case (funct)
                    F_SUB:   alu_op = ALU_SUB;
                    F_SLT:   alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_WB_R: begin
                dst      = 2'd1;
                reg_we_s = 1'b1;
            end
            S_EXEC_I: begin
                alu_srcb = 2'd2;
                if (opcode == OP_XORI) begin
                    alu_op = ALU_XOR;
                end else begin
                    alu_op = ALU_ADD;
                end
            end
            S_WB_I:     reg_we_s = 1'b1;
            S_MEM_ADDR: alu_srcb = 2'd2;
            S_MEM_RD:   req_s    = 1'b1;
            S_MEM_WB: begin
                reg_in   = 1'b1;
                reg_we_s = 1'b1;
            end
            S_MEM_WR: begin
                req_s    = 1'b1;
                mem_we_s = mem_ready;
            end
            S_BNE: begin
                alu_srcb = 2'd1;
                alu_op   = ALU_SUB;
                if (!zero) begin
                    pc_src  = 2'd2;
                    pc_we_s = 1'b1;
                end else begin
                    pc_we_s = 1'b0;
                end
            end
            S_J:        pc_we_s  = 1'b1;
            // PC already holds PC+1 here, so ALU out = PC+2 becomes the link.
            S_JAL_LINK: alu_srca = 1'b1;
            S_JAL: begin
                pc_we_s  = 1'b1;
                dst      = 2'd2;
                reg_we_s = 1'b1;
            end
            S_JR: begin
                pc_src  = 2'd3;
                pc_we_s = 1'b1;
            end
            S_FAULT: begin
            end
            default: begin
            end
        endcase
    end

    // State register and wait-state counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= S_FETCH;
            wait_cnt_r <= {WCW{1'b0}};
        end else begin
            if (req_s && !mem_ready) begin
                wait_cnt_r <= wait_cnt_r + WCW'(1);
            end else begin
                wait_cnt_r <= {WCW{1'b0}};
            end
            case (state_r)
                S_FETCH: begin
                    if (mem_ready)      state_r <= S_DECODE;
                    else if (timeout_s) state_r <= S_FAULT;
                    else                state_r <= S_FETCH;
                end
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE: begin
                            case (funct)
                                F_ADD, F_SUB, F_SLT: state_r <= S_EXEC_R;
                                F_JR:                state_r <= S_JR;
                                default:             state_r <= S_FAULT;
                            endcase
                        end
                        OP_LW, OP_SW:     state_r <= S_MEM_ADDR;
                        OP_ADDI, OP_XORI: state_r <= S_EXEC_I;
                        OP_BNE:           state_r <= S_BNE;
                        OP_J:             state_r <= S_J;
                        OP_JAL:           state_r <= S_JAL_LINK;
                        default:          state_r <= S_FAULT;
                    endcase
                end
                S_EXEC_R:   state_r <= S_WB_R;
                S_EXEC_I:   state_r <= S_WB_I;
                S_MEM_ADDR: state_r <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: begin
                    if (mem_ready)      state_r <= S_MEM_WB;
                    else if (timeout_s) state_r <= S_FAULT;
                    else                state_r <= S_MEM_RD;
                end
                S_MEM_WR: begin
                    if (mem_ready)      state_r <= S_FETCH;
                    else if (timeout_s) state_r <= S_FAULT;
                    else                state_r <= S_MEM_WR;
                end
                S_JAL_LINK: state_r <= S_JAL;
                S_WB_R, S_WB_I, S_MEM_WB, S_BNE, S_J, S_JAL, S_JR:
                            state_r <= S_FETCH;
                S_FAULT:    state_r <= S_FAULT;
                default:    state_r <= S_FAULT;
            endcase
        end
    end

`ifdef MC_CTRL_PERF_CNT_EN
    logic to_fetch_s;

    // Flags the cycles whose clock edge retires an instruction back to FETCH.
    always_comb begin
        to_fetch_s = 1'b0;
        case (state_r)
            S_WB_R, S_WB_I, S_MEM_WB, S_BNE, S_J, S_JAL, S_JR: to_fetch_s = 1'b1;
            S_MEM_WR: to_fetch_s = mem_ready;
            default:  to_fetch_s = 1'b0;
        endcase
    end

    // Performance counters; both wrap naturally at 2^CNTW.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt  <= {CNTW{1'b0}};
            retire_cnt <= {CNTW{1'b0}};
        end else begin
            if (state_r != S_FAULT) begin
                cycle_cnt <= cycle_cnt + CNTW'(1);
            end else begin
                cycle_cnt <= cycle_cnt;
            end
            if (to_fetch_s) begin
                retire_cnt <= retire_cnt + CNTW'(1);
            end else begin
                retire_cnt <= retire_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for mc_ctrl_fsm. Inputs change on the falling
// edge; the combinational outputs are sampled 1 time unit later, and each step
// is checked against a hand-written control word.
// Control word: {mem_req, pc_we, mem_in, mem_we, ir_we, alu_srca, alu_srcb[2],
//                alu_op[6], pc_src[2], dst[2], reg_in, reg_we, fault}
// Sequence entry: {mem_ready, zero, control word}
// -----------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, pc_we, mem_in, mem_we, ir_we, alu_srca, reg_in, reg_we, fault;
    logic [1:0] alu_srcb, pc_src, dst;
    logic [5:0] alu_op;
`ifdef MC_CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, retire_cnt;
`endif

    int total = 0;
    int bad = 0;
    logic [20:0] ctl;
    logic [22:0] seq[$];

    assign ctl = {mem_req, pc_we, mem_in, mem_we, ir_we, alu_srca, alu_srcb,
                  alu_op, pc_src, dst, reg_in, reg_we, fault};

    localparam logic [20:0] E_FETCH_RDY  = {6'b111011, 2'd0, 6'd0, 2'd1, 2'd0, 3'b000};
    localparam logic [20:0] E_FETCH_WAIT = {6'b101000, 2'd0, 6'd0, 2'd0, 2'd0, 3'b000};
    localparam logic [20:0] E_RST_RDY    = {6'b001001, 2'd0, 6'd0, 2'd1, 2'd0, 3'b000};
    localparam logic [20:0] E_DEC        = {6'b000001, 2'd3, 6'd0, 2'd0, 2'd0, 3'b000};
    localparam logic [20:0] E_EXR_ADD    = {6'b000000, 2'd1, 6'd0, 2'd0, 2'd0, 3'b000};
    localparam logic [20:0] E_EXR_SUB    = {6'b000000, 2'd1, 6'd1, 2'd0, 2'd0, 3'b000};
    localparam logic [20:0] E_EXR_SLT    = {6'b000000, 2'd1, 6'd3, 2'd0, 2'd0, 3'b000};
    localparam logic [20:0] E_WB_R       = {6'b000000, 2'd0, 6'd0, 2'd0, 2'd1, 3'b010};
    localparam logic [20:0] E_EXI_ADD    = {6'b000000, 2'd2, 6'd0, 2'd0, 2'd0, 3'b000};
    localparam logic [20:0] E_EXI_XOR    = {6'b000000, 2'd2, 6'd2, 2'd0, 2'd0, 3'b000};
    localparam logic [20:0] E_WB_I       = {6'b000000, 2'd0, 6'd0, 2'd0, 2'd0, 3'b010};
    localparam logic [20:0] E_MADDR      = {6'b000000, 2'd2, 6'd0, 2'd0, 2'd0, 3'b000};
    localparam logic [20:0] E_MRD        = {6'b100000, 2'd0, 6'd0, 2'd0, 2'd0, 3'b000};
    localparam logic [20:0] E_MWB        = {6'b000000, 2'd0, 6'd0, 2'd0, 2'd0, 3'b110};
    localparam logic [20:0] E_MWR_RDY    = {6'b100100, 2'd0, 6'd0, 2'd0, 2'd0, 3'b000};
    localparam logic [20:0] E_BNE_TAKEN  = {6'b010000, 2'd1, 6'd1, 2'd2, 2'd0, 3'b000};
    localparam logic [20:0] E_BNE_NOT    = {6'b000000, 2'd1, 6'd1, 2'd0, 2'd0, 3'b000};
    localparam logic [20:0] E_J          = {6'b010000, 2'd0, 6'd0, 2'd0, 2'd0, 3'b000};
    localparam logic [20:0] E_JAL_LINK   = {6'b000001, 2'd0, 6'd0, 2'd0, 2'd0, 3'b000};
    localparam logic [20:0] E_JAL        = {6'b010000, 2'd0, 6'd0, 2'd0, 2'd2, 3'b010};
    localparam logic [20:0] E_JR         = {6'b010000, 2'd0, 6'd0, 2'd3, 2'd0, 3'b000};
    localparam logic [20:0] E_FAULT      = {6'b000000, 2'd0, 6'd0, 2'd0, 2'd0, 3'b001};

    mc_ctrl_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .pc_we(pc_we), .mem_in(mem_in),
        .mem_we(mem_we), .ir_we(ir_we), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
        .alu_op(alu_op), .pc_src(pc_src), .dst(dst), .reg_in(reg_in),
        .reg_we(reg_we), .fault(fault)
`ifdef MC_CTRL_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [22:0] st(input logic rdy, input logic z, input logic [20:0] e);
        return {rdy, z, e};
    endfunction

    // Leaves the bench at a falling edge with the DUT freshly out of reset.
    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        zero = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (ctl !== E_RST_RDY) begin
            bad++;
            $display("FAIL reset_gating: got %h want %h", ctl, E_RST_RDY);
        end
        reset = 1'b0;
        #1;
        total++;
        if (ctl !== E_FETCH_RDY) begin
            bad++;
            $display("FAIL reset_state: got %h want %h", ctl, E_FETCH_RDY);
        end
        @(negedge clk);
    endtask

    task automatic test_rtype();
        logic [5:0]  fn [3] = '{6'h20, 6'h22, 6'h2A};
        logic [20:0] ex [3] = '{E_EXR_ADD, E_EXR_SUB, E_EXR_SLT};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            opcode = 6'h00;
            funct = fn[k];
            seq = '{st(1'b1, 1'b0, E_FETCH_RDY), st(1'b1, 1'b0, E_DEC), st(1'b1, 1'b0, ex[k]),
                    st(1'b1, 1'b0, E_WB_R), st(1'b1, 1'b0, E_FETCH_RDY)};
            for (int i = 0; i < seq.size(); i++) begin
                mem_ready = seq[i][22];
                zero = seq[i][21];
                #1;
                total++;
                if (ctl !== seq[i][20:0]) begin
                    bad++;
                    $display("FAIL rtype f=%h step %0d: got %h want %h", fn[k], i, ctl, seq[i][20:0]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_itype();
        logic [5:0]  op [2] = '{6'h08, 6'h0E};
        logic [20:0] ex [2] = '{E_EXI_ADD, E_EXI_XOR};
        for (int k = 0; k < 2; k++) begin
            do_reset();
            opcode = op[k];
            funct = 6'h3F;
            seq = '{st(1'b1, 1'b0, E_FETCH_RDY), st(1'b0, 1'b0, E_DEC), st(1'b0, 1'b0, ex[k]),
                    st(1'b0, 1'b0, E_WB_I), st(1'b1, 1'b0, E_FETCH_RDY)};
            for (int i = 0; i < seq.size(); i++) begin
                mem_ready = seq[i][22];
                zero = seq[i][21];
                #1;
                total++;
                if (ctl !== seq[i][20:0]) begin
                    bad++;
                    $display("FAIL itype op=%h step %0d: got %h want %h", op[k], i, ctl, seq[i][20:0]);
                end
                @(negedge clk);
            end
        end
    endtask

    // LW with three wait states: mem_req stays high for four MEM_RD cycles.
    task automatic test_lw();
        do_reset();
        opcode = 6'h23;
        seq = '{st(1'b1, 1'b0, E_FETCH_RDY), st(1'b1, 1'b0, E_DEC), st(1'b0, 1'b0, E_MADDR),
                st(1'b0, 1'b0, E_MRD), st(1'b0, 1'b0, E_MRD), st(1'b0, 1'b0, E_MRD),
                st(1'b1, 1'b0, E_MRD), st(1'b0, 1'b0, E_MWB), st(1'b0, 1'b0, E_FETCH_WAIT)};
        for (int i = 0; i < seq.size(); i++) begin
            mem_ready = seq[i][22];
            zero = seq[i][21];
            #1;
            total++;
            if (ctl !== seq[i][20:0]) begin
                bad++;
                $display("FAIL lw step %0d: got %h want %h", i, ctl, seq[i][20:0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sw();
        do_reset();
        opcode = 6'h2B;
        seq = '{st(1'b1, 1'b0, E_FETCH_RDY), st(1'b0, 1'b0, E_DEC), st(1'b0, 1'b0, E_MADDR),
                st(1'b0, 1'b0, E_MRD), st(1'b1, 1'b0, E_MWR_RDY), st(1'b1, 1'b0, E_FETCH_RDY)};
        for (int i = 0; i < seq.size(); i++) begin
            mem_ready = seq[i][22];
            zero = seq[i][21];
            #1;
            total++;
            if (ctl !== seq[i][20:0]) begin
                bad++;
                $display("FAIL sw step %0d: got %h want %h", i, ctl, seq[i][20:0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bne();
        logic        zv [2] = '{1'b1, 1'b0};
        logic [20:0] ex [2] = '{E_BNE_NOT, E_BNE_TAKEN};
        for (int k = 0; k < 2; k++) begin
            do_reset();
            opcode = 6'h05;
            seq = '{st(1'b1, 1'b0, E_FETCH_RDY), st(1'b0, zv[k], E_DEC), st(1'b0, zv[k], ex[k]),
                    st(1'b1, 1'b0, E_FETCH_RDY)};
            for (int i = 0; i < seq.size(); i++) begin
                mem_ready = seq[i][22];
                zero = seq[i][21];
                #1;
                total++;
                if (ctl !== seq[i][20:0]) begin
                    bad++;
                    $display("FAIL bne zero=%0d step %0d: got %h want %h", zv[k], i, ctl, seq[i][20:0]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_jumps();
        logic [5:0]  op [3] = '{6'h02, 6'h00, 6'h03};
        logic [5:0]  fn [3] = '{6'h00, 6'h08, 6'h00};
        logic [20:0] e2 [3] = '{E_J, E_JR, E_JAL_LINK};
        logic [20:0] e3 [3] = '{E_FETCH_RDY, E_FETCH_RDY, E_JAL};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            opcode = op[k];
            funct = fn[k];
            seq = '{st(1'b1, 1'b0, E_FETCH_RDY), st(1'b1, 1'b0, E_DEC), st(1'b1, 1'b0, e2[k]),
                    st(1'b1, 1'b0, e3[k])};
            if (k == 2) seq.push_back(st(1'b1, 1'b0, E_FETCH_RDY));
            for (int i = 0; i < seq.size(); i++) begin
                mem_ready = seq[i][22];
                zero = seq[i][21];
                #1;
                total++;
                if (ctl !== seq[i][20:0]) begin
                    bad++;
                    $display("FAIL jump op=%h step %0d: got %h want %h", op[k], i, ctl, seq[i][20:0]);
                end
                @(negedge clk);
            end
        end
    endtask

    // Fifteen unanswered FETCH cycles, then FAULT (ignoring a late mem_ready).
    task automatic test_timeout();
        do_reset();
        opcode = 6'h00;
        funct = 6'h20;
        seq = {};
        for (int i = 0; i < 15; i++) seq.push_back(st(1'b0, 1'b0, E_FETCH_WAIT));
        seq.push_back(st(1'b0, 1'b0, E_FAULT));
        seq.push_back(st(1'b1, 1'b0, E_FAULT));
        seq.push_back(st(1'b0, 1'b0, E_FAULT));
        for (int i = 0; i < seq.size(); i++) begin
            mem_ready = seq[i][22];
            zero = seq[i][21];
            #1;
            total++;
            if (ctl !== seq[i][20:0]) begin
                bad++;
                $display("FAIL timeout step %0d: got %h want %h", i, ctl, seq[i][20:0]);
            end
            @(negedge clk);
        end
        do_reset();
        #1;
        total++;
        if (ctl !== E_FETCH_WAIT) begin
            bad++;
            $display("FAIL timeout_recover: got %h want %h", ctl, E_FETCH_WAIT);
        end
        @(negedge clk);
    endtask

    task automatic test_undef();
        do_reset();
        opcode = 6'h3F;
        seq = '{st(1'b1, 1'b0, E_FETCH_RDY), st(1'b1, 1'b0, E_DEC), st(1'b1, 1'b0, E_FAULT),
                st(1'b1, 1'b0, E_FAULT)};
        for (int i = 0; i < seq.size(); i++) begin
            mem_ready = seq[i][22];
            zero = seq[i][21];
            #1;
            total++;
            if (ctl !== seq[i][20:0]) begin
                bad++;
                $display("FAIL undef step %0d: got %h want %h", i, ctl, seq[i][20:0]);
            end
            @(negedge clk);
        end
    endtask

    // Reset raised between clock edges while MEM_WR is completing.
    task automatic test_reset_mid_wr();
        do_reset();
        opcode = 6'h2B;
        seq = '{st(1'b1, 1'b0, E_FETCH_RDY), st(1'b0, 1'b0, E_DEC), st(1'b0, 1'b0, E_MADDR)};
        for (int i = 0; i < seq.size(); i++) begin
            mem_ready = seq[i][22];
            zero = seq[i][21];
            #1;
            total++;
            if (ctl !== seq[i][20:0]) begin
                bad++;
                $display("FAIL mid_wr step %0d: got %h want %h", i, ctl, seq[i][20:0]);
            end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        total++;
        if ({mem_req, mem_we} !== 2'b11) begin
            bad++;
            $display("FAIL mid_wr_active: got req/we=%b want 11", {mem_req, mem_we});
        end
        reset = 1'b1;
        #1;
        total++;
        if ({mem_req, mem_we, fault} !== 3'b000) begin
            bad++;
            $display("FAIL mid_wr_reset: got req/we/fault=%b want 000", {mem_req, mem_we, fault});
        end
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;
    endtask

`ifdef MC_CTRL_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        opcode = 6'h00;
        funct = 6'h20;
        mem_ready = 1'b1;
        #1;
        total++;
        if ({cycle_cnt, retire_cnt} !== 64'd0) begin
            bad++;
            $display("FAIL perf_reset: got cyc=%0d ret=%0d want 0 0", cycle_cnt, retire_cnt);
        end
        repeat (12) @(negedge clk);
        #1;
        total++;
        if (cycle_cnt !== 32'd12 || retire_cnt !== 32'd3) begin
            bad++;
            $display("FAIL perf_count: got cyc=%0d ret=%0d want 12 3", cycle_cnt, retire_cnt);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_lw();
        test_sw();
        test_bne();
        test_jumps();
        test_timeout();
        test_undef();
        test_reset_mid_wr();
`ifdef MC_CTRL_PERF_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
